// File: rtl/ahb_s2m_mux.sv
// ahb_s2m_mux: response-path mux of an AHB matrix.
// Routes each slave's hrdata/hready/hresp back to the master that owns that
// slave's data phase. It tracks one data phase per master. It generates the
// default-slave two-cycle ERROR for unmapped addresses. It also buffers a
// completed response while the master's next address is still waiting for a grant.
//
// Ports:
//   hclk      bus clock, all state on the rising edge
//   hreset    synchronous active-high reset
//   grant_s   per-slave one-hot grant vector over masters (all zero = idle)
//   htrans_m  per-master htrans
//   hmatch_m  per-master "address decodes to some slave"
//   hrdata_s  per-slave read data
//   hready_s  per-slave hreadyout
//   hresp_s   per-slave hresp (1 = ERROR)
//   hrdata_m  per-master read data
//   hready_m  per-master hready
//   hresp_m   per-master hresp
module ahb_s2m_mux #(
  parameter int unsigned HMAS_NUM   = 5,
  parameter int unsigned HSLV_NUM   = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SIDX_W     = (HSLV_NUM > 1) ? $clog2(HSLV_NUM) : 1
) (
  input  logic                                 hclk,
  input  logic                                 hreset,
  input  logic [HSLV_NUM-1:0][HMAS_NUM-1:0]    grant_s,
  input  logic [HMAS_NUM-1:0][1:0]             htrans_m,
  input  logic [HMAS_NUM-1:0]                  hmatch_m,
  input  logic [HSLV_NUM-1:0][DATA_WIDTH-1:0]  hrdata_s,
  input  logic [HSLV_NUM-1:0]                  hready_s,
  input  logic [HSLV_NUM-1:0]                  hresp_s,
  output logic [HMAS_NUM-1:0][DATA_WIDTH-1:0]  hrdata_m,
  output logic [HMAS_NUM-1:0]                  hready_m,
  output logic [HMAS_NUM-1:0]                  hresp_m
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StSlv  = 3'd1;
  localparam logic [2:0] StHold = 3'd2;
  localparam logic [2:0] StErr1 = 3'd3;
  localparam logic [2:0] StErr2 = 3'd4;

  logic [2:0]            state_q    [HMAS_NUM];
  logic [2:0]            state_d    [HMAS_NUM];
  logic [SIDX_W-1:0]     didx_q     [HMAS_NUM];
  logic [SIDX_W-1:0]     didx_d     [HMAS_NUM];
  logic [DATA_WIDTH-1:0] buf_data_q [HMAS_NUM];
  logic [DATA_WIDTH-1:0] buf_data_d [HMAS_NUM];
  logic                  buf_resp_q [HMAS_NUM];
  logic                  buf_resp_d [HMAS_NUM];

  logic                  act        [HMAS_NUM];
  logic                  gnt        [HMAS_NUM];
  logic [SIDX_W-1:0]     sidx       [HMAS_NUM];
  logic                  addr_ok    [HMAS_NUM];
  logic                  accept     [HMAS_NUM];

  // Address-side decode. The low-to-high priority comes from the descending
  // loop, where the last assignment wins. That leaves the lowest granting slave in sidx.
  always_comb begin
    for (int m = 0; m < int'(HMAS_NUM); m++) begin
      act[m]  = htrans_m[m][1];
      gnt[m]  = 1'b0;
      sidx[m] = '0;
      for (int s = int'(HSLV_NUM) - 1; s >= 0; s--) begin
        if (grant_s[s][m]) begin
          gnt[m]  = 1'b1;
          sidx[m] = SIDX_W'(s);
        end
      end
      // The next address can be taken when nothing is pending for any slave.
      addr_ok[m] = !act[m] || !hmatch_m[m] || gnt[m];
    end
  end

  always_comb begin
    for (int m = 0; m < int'(HMAS_NUM); m++) begin
      state_d[m]    = state_q[m];
      didx_d[m]     = didx_q[m];
      buf_data_d[m] = buf_data_q[m];
      buf_resp_d[m] = buf_resp_q[m];
      accept[m]     = 1'b0;
      hready_m[m]   = 1'b1;
      hresp_m[m]    = 1'b0;
      hrdata_m[m]   = '0;

      case (state_q[m])
        StIdle: begin
          hready_m[m] = addr_ok[m];
          accept[m]   = addr_ok[m];
        end
        StSlv: begin
          hrdata_m[m] = hrdata_s[didx_q[m]];
          hresp_m[m]  = hresp_s[didx_q[m]];
          if (hready_s[didx_q[m]]) begin
            if (addr_ok[m]) begin
              hready_m[m] = 1'b1;
              accept[m]   = 1'b1;
            end else begin
              // The slave has finished but the master's next address has no grant yet.
              // Park the response in the buffer and release the slave.
              hready_m[m]   = 1'b0;
              buf_data_d[m] = hrdata_s[didx_q[m]];
              buf_resp_d[m] = hresp_s[didx_q[m]];
              state_d[m]    = StHold;
            end
          end else begin
            hready_m[m] = 1'b0;
          end
        end
        StHold: begin
          hready_m[m] = addr_ok[m];
          hrdata_m[m] = buf_data_q[m];
          hresp_m[m]  = buf_resp_q[m];
          accept[m]   = addr_ok[m];
        end
        StErr1: begin
          hready_m[m] = 1'b0;
          hresp_m[m]  = 1'b1;
          state_d[m]  = StErr2;
        end
        StErr2: begin
          hready_m[m] = addr_ok[m];
          hresp_m[m]  = 1'b1;
          accept[m]   = addr_ok[m];
        end
        default: begin
          state_d[m] = StIdle;
        end
      endcase

      if (accept[m]) begin
        if (!act[m]) begin
          state_d[m] = StIdle;
        end else if (hmatch_m[m]) begin
          state_d[m] = StSlv;
          didx_d[m]  = sidx[m];
        end else begin
          state_d[m] = StErr1;
        end
      end

      if (hreset) begin
        hready_m[m] = 1'b1;
        hresp_m[m]  = 1'b0;
        hrdata_m[m] = '0;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      for (int m = 0; m < int'(HMAS_NUM); m++) begin
        state_q[m]    <= StIdle;
        didx_q[m]     <= '0;
        buf_data_q[m] <= '0;
        buf_resp_q[m] <= 1'b0;
      end
    end else begin
      for (int m = 0; m < int'(HMAS_NUM); m++) begin
        state_q[m]    <= state_d[m];
        didx_q[m]     <= didx_d[m];
        buf_data_q[m] <= buf_data_d[m];
        buf_resp_q[m] <= buf_resp_d[m];
      end
    end
  end

endmodule

// File: tb/tb_ahb_s2m_mux.sv
// Bench for ahb_s2m_mux. The bench drives directed vectors and pins them with
// literal expectations. A transaction-level model is compared with every master's
// outputs on every cycle.
module tb_ahb_s2m_mux;

  localparam int HM = 5;
  localparam int HS = 4;
  localparam int DW = 32;

  logic                    hclk;
  logic                    hreset;
  logic [HS-1:0][HM-1:0]   grant_s;
  logic [HM-1:0][1:0]      htrans_m;
  logic [HM-1:0]           hmatch_m;
  logic [HS-1:0][DW-1:0]   hrdata_s;
  logic [HS-1:0]           hready_s;
  logic [HS-1:0]           hresp_s;
  logic [HM-1:0][DW-1:0]   hrdata_m;
  logic [HM-1:0]           hready_m;
  logic [HM-1:0]           hresp_m;

  int checks = 0;
  int errors = 0;

  ahb_s2m_mux #(
    .HMAS_NUM   (HM),
    .HSLV_NUM   (HS),
    .DATA_WIDTH (DW)
  ) dut (
    .hclk     (hclk),
    .hreset   (hreset),
    .grant_s  (grant_s),
    .htrans_m (htrans_m),
    .hmatch_m (hmatch_m),
    .hrdata_s (hrdata_s),
    .hready_s (hready_s),
    .hresp_s  (hresp_s),
    .hrdata_m (hrdata_m),
    .hready_m (hready_m),
    .hresp_m  (hresp_m)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction model. Each master has an outstanding phase: none (0),
  // slave transfer (1), or unmapped error (2). A slave transfer may already
  // have its response parked. An error remembers whether its first cycle is done.
  // ---------------------------------------------------------------------------
  int              ph   [HM];
  int              slv  [HM];
  bit              errd [HM];
  bit              hb   [HM];
  logic [DW-1:0]   bd   [HM];
  logic            br   [HM];

  always @(negedge hclk) begin
    bit            a, mt, found, aok, er, ep;
    int            lo, ng;
    logic [DW-1:0] ed;
    for (int m = 0; m < HM; m++) begin
      a     = htrans_m[m][1];
      mt    = hmatch_m[m];
      found = 1'b0;
      lo    = 0;
      ng    = 0;
      for (int s = 0; s < HS; s++) begin
        if (grant_s[s][m]) begin
          ng++;
          if (!found) begin
            found = 1'b1;
            lo    = s;
          end
        end
      end
      if (ng > 1) begin
        errors++;
        $display("FAIL dbl_grant m%0d count=%0d required<=1", m, ng);
      end
      aok = !a || !mt || found;

      if (hreset) begin
        er = 1'b1; ep = 1'b0; ed = '0;
        ph[m] = 0; hb[m] = 1'b0; errd[m] = 1'b0;
      end else begin
        er = aok; ep = 1'b0; ed = '0;
        if (ph[m] == 1) begin
          if (hb[m]) begin
            ed = bd[m]; ep = br[m];
          end else begin
            ed = hrdata_s[slv[m]]; ep = hresp_s[slv[m]];
            er = hready_s[slv[m]] && aok;
            if (hready_s[slv[m]] && !aok) begin
              hb[m] = 1'b1; bd[m] = hrdata_s[slv[m]]; br[m] = hresp_s[slv[m]];
            end
          end
        end else if (ph[m] == 2) begin
          ep = 1'b1;
          if (!errd[m]) er = 1'b0;
          errd[m] = 1'b1;
        end
        if (er) begin
          hb[m] = 1'b0; errd[m] = 1'b0;
          if (!a) ph[m] = 0;
          else if (mt) begin ph[m] = 1; slv[m] = lo; end
          else ph[m] = 2;
        end
      end

      chk($sformatf("model_rdy_m%0d", m), 32'(hready_m[m]), 32'(er));
      chk($sformatf("model_rsp_m%0d", m), 32'(hresp_m[m]), 32'(ep));
      chk($sformatf("model_dat_m%0d", m), hrdata_m[m], ed);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus. Inputs change 1 time unit after each rising edge.
  // Literal checks are made on the falling edge.
  // ---------------------------------------------------------------------------
  task automatic nxt();
    @(posedge hclk);
    #1;
  endtask

  task automatic neg();
    @(negedge hclk);
  endtask

  task automatic idle_all();
    grant_s  = '0;
    htrans_m = '0;
    hmatch_m = '0;
    hrdata_s = '0;
    hready_s = '1;
    hresp_s  = '0;
  endtask

  initial begin
    hreset = 1'b1;
    idle_all();
    // Reset with activity present on the inputs.
    htrans_m[1] = 2'b10;
    hready_s    = '0;
    neg();
    chk("rst_rdy", 32'(hready_m), 32'h1f);
    chk("rst_rsp", 32'(hresp_m), 32'h0);
    chk("rst_dat1", hrdata_m[1], 32'h0);
    nxt();
    idle_all();
    nxt();
    hreset = 1'b0;
    nxt();

    // M0 read on slave 1 with two wait states.
    htrans_m[0] = 2'b10; hmatch_m[0] = 1'b1; grant_s[1] = 5'b00001;
    neg(); chk("t1_addr_rdy", 32'(hready_m[0]), 32'h1);
    nxt(); idle_all(); hready_s[1] = 1'b0;
    neg(); chk("t1_w0", 32'(hready_m[0]), 32'h0);
    nxt();
    neg(); chk("t1_w1", 32'(hready_m[0]), 32'h0);
    nxt(); hready_s[1] = 1'b1; hrdata_s[1] = 32'hCAFE0001;
    neg();
    chk("t1_rdy", 32'(hready_m[0]), 32'h1);
    chk("t1_dat", hrdata_m[0], 32'hCAFE0001);
    chk("t1_rsp", 32'(hresp_m[0]), 32'h0);
    nxt(); idle_all();

    // M2 unmapped address: two-cycle default-slave ERROR.
    htrans_m[2] = 2'b10; hmatch_m[2] = 1'b0;
    neg(); chk("t2_addr_rdy", 32'(hready_m[2]), 32'h1);
    nxt(); idle_all();
    neg();
    chk("t2_e1_rdy", 32'(hready_m[2]), 32'h0);
    chk("t2_e1_rsp", 32'(hresp_m[2]), 32'h1);
    nxt();
    neg();
    chk("t2_e2_rdy", 32'(hready_m[2]), 32'h1);
    chk("t2_e2_rsp", 32'(hresp_m[2]), 32'h1);
    nxt();
    neg(); chk("t2_after_rsp", 32'(hresp_m[2]), 32'h0);
    nxt();

    // M1 on slave 0 completes while the next NONSEQ to slave 2 waits 3 cycles.
    htrans_m[1] = 2'b10; hmatch_m[1] = 1'b1; grant_s[0] = 5'b00010;
    neg(); chk("t3_addr_rdy", 32'(hready_m[1]), 32'h1);
    nxt(); grant_s = '0; hrdata_s[0] = 32'h1234;
    neg(); chk("t3_w0", 32'(hready_m[1]), 32'h0);
    nxt(); hrdata_s[0] = 32'hDEAD0000;
    neg(); chk("t3_w1", 32'(hready_m[1]), 32'h0);
    nxt();
    neg(); chk("t3_w2", 32'(hready_m[1]), 32'h0);
    nxt(); grant_s[2] = 5'b00010;
    neg();
    chk("t3_rdy", 32'(hready_m[1]), 32'h1);
    chk("t3_buf_dat", hrdata_m[1], 32'h1234);
    nxt(); idle_all(); hrdata_s[2] = 32'h5555;
    neg();
    chk("t3_s2_rdy", 32'(hready_m[1]), 32'h1);
    chk("t3_s2_dat", hrdata_m[1], 32'h5555);
    nxt(); idle_all();

    // M0 on slave 0 and M3 on slave 3. Slave 0's grant moves to M3 mid-phase.
    htrans_m[0] = 2'b10; hmatch_m[0] = 1'b1; grant_s[0] = 5'b00001;
    htrans_m[3] = 2'b10; hmatch_m[3] = 1'b1; grant_s[3] = 5'b01000;
    neg(); chk("t4_addr_rdy", 32'(hready_m), 32'h1f);
    nxt(); idle_all(); grant_s[0] = 5'b01000;
    hready_s[0] = 1'b0; hready_s[3] = 1'b0;
    hrdata_s[0] = 32'hA0A0; hrdata_s[3] = 32'hB3B3;
    neg();
    chk("t4_w_m0", 32'(hready_m[0]), 32'h0);
    chk("t4_w_m3", 32'(hready_m[3]), 32'h0);
    nxt(); hready_s[0] = 1'b1; hready_s[3] = 1'b1;
    neg();
    chk("t4_dat_m0", hrdata_m[0], 32'hA0A0);
    chk("t4_dat_m3", hrdata_m[3], 32'hB3B3);
    chk("t4_rdy", 32'(hready_m), 32'h1f);
    nxt(); idle_all();

    // Slave 2 two-cycle ERROR to M4.
    htrans_m[4] = 2'b10; hmatch_m[4] = 1'b1; grant_s[2] = 5'b10000;
    neg();
    nxt(); idle_all(); hready_s[2] = 1'b0; hresp_s[2] = 1'b1;
    neg();
    chk("t5_e1_rdy", 32'(hready_m[4]), 32'h0);
    chk("t5_e1_rsp", 32'(hresp_m[4]), 32'h1);
    nxt(); hready_s[2] = 1'b1;
    neg();
    chk("t5_e2_rdy", 32'(hready_m[4]), 32'h1);
    chk("t5_e2_rsp", 32'(hresp_m[4]), 32'h1);
    nxt(); idle_all();
    neg(); chk("t5_after_rsp", 32'(hresp_m[4]), 32'h0);
    nxt();

    // M2 back-to-back: slave 1, then slave 3, with no wait states.
    htrans_m[2] = 2'b10; hmatch_m[2] = 1'b1; grant_s[1] = 5'b00100;
    neg();
    nxt(); grant_s = '0; grant_s[3] = 5'b00100; hrdata_s[1] = 32'h11;
    neg();
    chk("t7_b0_rdy", 32'(hready_m[2]), 32'h1);
    chk("t7_b0_dat", hrdata_m[2], 32'h11);
    nxt(); idle_all(); hrdata_s[3] = 32'h33;
    neg(); chk("t7_b1_dat", hrdata_m[2], 32'h33);
    nxt(); idle_all();

    // Reset while M1 holds a buffered response.
    htrans_m[1] = 2'b10; hmatch_m[1] = 1'b1; grant_s[0] = 5'b00010;
    neg();
    nxt(); grant_s = '0; hrdata_s[0] = 32'hBEEF;
    neg(); chk("t6_hold_rdy", 32'(hready_m[1]), 32'h0);
    nxt(); idle_all(); hreset = 1'b1;
    neg();
    chk("t6_rst_rdy", 32'(hready_m), 32'h1f);
    chk("t6_rst_dat", hrdata_m[1], 32'h0);
    nxt(); hreset = 1'b0;
    neg();
    chk("t6_post_rdy", 32'(hready_m), 32'h1f);
    chk("t6_post_rsp", 32'(hresp_m), 32'h0);
    chk("t6_post_dat", hrdata_m[1], 32'h0);
    nxt(); htrans_m[1] = 2'b10; hmatch_m[1] = 1'b1; grant_s[2] = 5'b00010;
    hrdata_s[0] = 32'hBEEF;
    neg();
    chk("t6_new_rdy", 32'(hready_m[1]), 32'h1);
    chk("t6_new_dat", hrdata_m[1], 32'h0);
    nxt(); idle_all(); hrdata_s[2] = 32'h77;
    neg(); chk("t6_s2_dat", hrdata_m[1], 32'h77);
    nxt(); idle_all();
    neg();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
